// File: rtl/axil_master.sv
// AXI4-Lite master that sequences i2c_master_axil register accesses to move one
// 32-bit little-endian word to or from an FM24CLxx FRAM.
module axil_master #(
  parameter int         FM24CLXX_TYPE = 2048,
  parameter logic [2:0] FM24CLXX_ADDR = 3'b000,
  localparam int        AW            = $clog2(FM24CLXX_TYPE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] mem_address,
  input  logic [31:0]   data_in,
  output logic [31:0]   data_out,
  input  logic          write_enable,
  input  logic          read_enable,
  output logic          busy,
  output logic [3:0]    m_axil_awaddr,
  output logic          m_axil_awvalid,
  input  logic          m_axil_awready,
  output logic [31:0]   m_axil_wdata,
  output logic [3:0]    m_axil_wstrb,
  output logic          m_axil_wvalid,
  input  logic          m_axil_wready,
  input  logic [1:0]    m_axil_bresp,
  input  logic          m_axil_bvalid,
  output logic          m_axil_bready,
  output logic [3:0]    m_axil_araddr,
  output logic          m_axil_arvalid,
  input  logic          m_axil_arready,
  input  logic [31:0]   m_axil_rdata,
  input  logic [1:0]    m_axil_rresp,
  input  logic          m_axil_rvalid,
  output logic          m_axil_rready,
  output logic [2:0]    dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both 1; a valid stays high with stable payload until then
  // and drops the cycle after; only one AXI transaction is ever outstanding.

  localparam int         NA        = (FM24CLXX_TYPE > 2048) ? 2 : 1;
  localparam logic [2:0] NA3       = 3'(NA);
  localparam logic [2:0] LAST_STEP = 3'(NA + 4);

  typedef enum logic [2:0] {IDLE, AW_W, B_WAIT, AR, R_WAIT, DONE} state_t;

  state_t        state;
  logic          rd_op;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_data;
  logic [2:0]    step;
  logic [1:0]    rd_idx;
  logic [23:0]   rd_buf;
  logic          aw_done, w_done;
  logic          aw_fin, w_fin;
  logic [15:0]   addr16;
  logic          unused_resp;

  assign dbg_state    = state;
  assign m_axil_wstrb = 4'hF;
  assign addr16       = 16'(cap_addr);
  assign aw_fin       = aw_done | (m_axil_awvalid & m_axil_awready);
  assign w_fin        = w_done | (m_axil_wvalid & m_axil_wready);
  assign unused_resp  = ^{m_axil_bresp, m_axil_rresp, m_axil_rdata[31:9]};

  // Register address and write data for step s of a write (rd=0) or read (rd=1).
  function automatic logic [35:0] step_txn(input logic rd, input logic [2:0] s,
                                           input logic [15:0] a, input logic [31:0] d);
    logic [6:0]  dev;
    logic [3:0]  ad;
    logic [31:0] wd;
    logic [1:0]  k;
    dev = (FM24CLXX_TYPE > 2048) ? {4'b1010, FM24CLXX_ADDR} : {4'b1010, a[10:8]};
    ad  = 4'h8;
    wd  = '0;
    k   = 2'(s - NA3 - 3'd1);
    if (s == 3'd0) begin
      ad = 4'h4;
      wd = (rd ? 32'h0900 : 32'h1900) | {25'd0, dev};
    end else if (s <= NA3) begin
      wd = {24'd0, ((NA == 2) && (s == 3'd1)) ? a[15:8] : a[7:0]};
      if (rd && (s == NA3)) wd[9] = 1'b1;
    end else if (!rd) begin
      wd = {24'd0, d[{k, 3'b000} +: 8]};
      if (k == 2'd3) wd[9] = 1'b1;
    end else begin
      ad = 4'h4;
      case (3'(s - NA3))
        3'd1:    wd = 32'h0300 | {25'd0, dev};
        3'd4:    wd = 32'h1200 | {25'd0, dev};
        default: wd = 32'h0200 | {25'd0, dev};
      endcase
    end
    return {ad, wd};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rd_op          <= 1'b0;
      cap_addr       <= '0;
      cap_data       <= '0;
      step           <= '0;
      rd_idx         <= '0;
      rd_buf         <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      busy           <= 1'b0;
      data_out       <= '0;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start && (write_enable || read_enable)) begin
            rd_op          <= !write_enable;
            cap_addr       <= mem_address;
            cap_data       <= data_in;
            step           <= '0;
            {m_axil_awaddr, m_axil_wdata} <= step_txn(!write_enable, 3'd0,
                                                      16'(mem_address), data_in);
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid  <= 1'b1;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            busy           <= 1'b1;
            state          <= AW_W;
          end
        end
        AW_W: begin
          if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wvalid && m_axil_wready) m_axil_wvalid <= 1'b0;
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (aw_fin && w_fin) begin
            m_axil_bready <= 1'b1;
            state         <= B_WAIT;
          end
        end
        B_WAIT: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            if (step != LAST_STEP) begin
              step           <= step + 3'd1;
              {m_axil_awaddr, m_axil_wdata} <= step_txn(rd_op, step + 3'd1, addr16, cap_data);
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= AW_W;
            end else if (rd_op) begin
              rd_idx         <= '0;
              m_axil_araddr  <= 4'h8;
              m_axil_arvalid <= 1'b1;
              state          <= AR;
            end else begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        AR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            // A beat without the valid flag carries no byte; the same read is reissued.
            if (m_axil_rdata[8] && (rd_idx == 2'd3)) begin
              data_out <= {m_axil_rdata[7:0], rd_buf};
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              if (m_axil_rdata[8]) begin
                rd_buf[{rd_idx, 3'b000} +: 8] <= m_axil_rdata[7:0];
                rd_idx <= rd_idx + 2'd1;
              end
              m_axil_arvalid <= 1'b1;
              state          <= AR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: randomized AXI4-Lite slave responder, reference model of
// the expected register-write stream and read results, and a scoreboard monitor.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, write_enable, read_enable, busy;
  logic [10:0] mem_address;
  logic [31:0] data_in, data_out;
  logic [3:0]  awaddr, wstrb, araddr;
  logic [31:0] wdata, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  axil_master dut (
    .clk(clk), .rst(rst), .start(start), .mem_address(mem_address),
    .data_in(data_in), .data_out(data_out), .write_enable(write_enable),
    .read_enable(read_enable), .busy(busy),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
    .m_axil_wready(wready), .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
    .m_axil_bready(bready), .m_axil_araddr(araddr), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [35:0] exp_q[$];       // {register address, write data} in issue order
  logic [32:0] exp_done_q[$];  // {is_read, expected data_out} per accepted request
  logic [7:0]  rd_bytes_q[$];  // bytes the slave hands out on valid read beats
  logic [31:0] model_word = '0;

  int  aw_dly_cfg = 0, w_dly_cfg = 0, b_dly_cfg = 0, ar_dly_cfg = 0, r_dly_cfg = 0;
  int  inv_pct = 0;
  bit  force_inv = 1'b0;
  int  ar_total = 0, inv_total = 0, b_total = 0, bp_seen = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int cfg);
    return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
  endfunction

  // Reference model: register writes the sequencer must issue for one request.
  task automatic model_write(input logic [10:0] a, input logic [31:0] d);
    logic [31:0] dev;
    dev = {25'd0, 4'b1010, a[10:8]};
    exp_q.push_back({4'h4, 32'h1900 | dev});
    exp_q.push_back({4'h8, 24'd0, a[7:0]});
    for (int k = 0; k < 4; k++)
      exp_q.push_back({4'h8, ((k == 3) ? 32'h200 : 32'h0) | {24'd0, d[k*8 +: 8]}});
  endtask

  task automatic model_read(input logic [10:0] a);
    logic [31:0] dev;
    logic [31:0] cmds[4];
    dev  = {25'd0, 4'b1010, a[10:8]};
    cmds = '{32'h0300, 32'h0200, 32'h0200, 32'h1200};
    exp_q.push_back({4'h4, 32'h0900 | dev});
    exp_q.push_back({4'h8, 32'h200 | {24'd0, a[7:0]}});
    for (int k = 0; k < 4; k++) exp_q.push_back({4'h4, cmds[k] | dev});
  endtask

  // Slave responder: decides readies/responses on the falling edge so the DUT sees
  // them at the next rising edge; handshakes are recorded at decision time.
  initial begin : slave
    bit aw_got, w_got, ar_got;
    logic [3:0]  cap_awaddr;
    logic [31:0] cap_wdata;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    aw_got = 0; w_got = 0; ar_got = 0;
    aw_wait = -1; w_wait = -1; b_wait = -1; ar_wait = -1; r_wait = -1;
    cap_awaddr = '0; cap_wdata = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = 0;
      bresp = 2'($urandom); rresp = 2'($urandom);
      if (!rst) begin
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_wait = -1; w_wait = -1; b_wait = -1; ar_wait = -1; r_wait = -1;
        continue;
      end
      if (bready) begin
        check("bready_after_aw_w", 36'({aw_got, w_got, awvalid, wvalid}), 36'(4'b1100));
        if (aw_got && w_got) begin
          if (b_wait < 0) b_wait = pick(b_dly_cfg);
          if (b_wait == 0) begin
            bvalid = 1; b_total++; b_wait = -1;
            if (exp_q.size() == 0) check("unexpected_txn", {cap_awaddr, cap_wdata}, 36'hF_FFFF_FFFF);
            else check("aw_w_txn", {cap_awaddr, cap_wdata}, exp_q.pop_front());
            aw_got = 0; w_got = 0;
          end else b_wait--;
        end
      end
      if (w_got && !aw_got && awvalid) bp_seen++;
      if (aw_got) check("awvalid_drop", 36'(awvalid), 36'(0));
      if (w_got) check("wvalid_drop", 36'(wvalid), 36'(0));
      if (awvalid && !aw_got) begin
        if (aw_wait < 0) aw_wait = pick(aw_dly_cfg);
        if (aw_wait == 0) begin
          awready = 1; aw_got = 1; cap_awaddr = awaddr; aw_wait = -1;
        end else aw_wait--;
      end
      if (wvalid && !w_got) begin
        if (w_wait < 0) w_wait = pick(w_dly_cfg);
        if (w_wait == 0) begin
          wready = 1; w_got = 1; cap_wdata = wdata; w_wait = -1;
          check("wstrb", 36'(wstrb), 36'(4'hF));
        end else w_wait--;
      end
      if (rready) begin
        check("rready_after_ar", 36'({ar_got, arvalid}), 36'(2'b10));
        if (ar_got) begin
          if (r_wait < 0) r_wait = pick(r_dly_cfg);
          if (r_wait == 0) begin
            rvalid = 1; ar_got = 0; r_wait = -1;
            if (force_inv || rd_bytes_q.size() == 0 || $urandom_range(0, 99) < inv_pct) begin
              rdata = force_inv ? 32'h0 : ($urandom & 32'hFFFF_FEFF);
              force_inv = 0; inv_total++;
            end else begin
              rdata = $urandom;
              rdata[8] = 1'b1;
              rdata[7:0] = rd_bytes_q.pop_front();
            end
          end else r_wait--;
        end
      end
      if (arvalid && !ar_got) begin
        if (ar_wait < 0) ar_wait = pick(ar_dly_cfg);
        if (ar_wait == 0) begin
          arready = 1; ar_got = 1; ar_wait = -1; ar_total++;
          check("araddr", 36'(araddr), 36'(4'h8));
        end else ar_wait--;
      end
    end
  end

  // Completion monitor: every falling edge of busy retires one expected request.
  initial begin : done_monitor
    bit prev_busy;
    logic [32:0] e;
    prev_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst) prev_busy = 0;
      else begin
        if (prev_busy && !busy) begin
          if (exp_done_q.size() == 0) check("unexpected_done", 36'(data_out), 36'hF_FFFF_FFFF);
          else begin
            e = exp_done_q.pop_front();
            check("data_out", 36'(data_out), 36'(e[31:0]));
            check("b_count", 36'(b_total), 36'(6));
            check("ar_count", 36'(ar_total), e[32] ? 36'(4 + inv_total) : 36'(0));
          end
          ar_total = 0; inv_total = 0; b_total = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_ctrl", 36'({awvalid, wvalid, bready, arvalid, rready, busy}), 36'(0));
    check("rst_data_out", 36'(data_out), 36'(0));
    check("rst_addr_wdata", {awaddr, wdata}, 36'(0));
    check("rst_araddr_state", 36'({araddr, dbg_state}), 36'(0));
  endtask

  // Called just after a falling edge; asserts reset asynchronously mid-cycle.
  task automatic apply_reset();
    #2 rst = 0;
    start = 0; write_enable = 0; read_enable = 0;
    #1 check_reset_outputs();
    exp_q.delete(); exp_done_q.delete(); rd_bytes_q.delete();
    model_word = '0; ar_total = 0; inv_total = 0; b_total = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 36'(busy), 36'(0));
    if (busy) begin
      @(negedge clk);
      apply_reset();
    end
  endtask

  // For a read, d is the word the slave will return byte by byte.
  task automatic do_req(input bit wr, input bit rd, input logic [10:0] a,
                        input logic [31:0] d, input bit pulse_busy, input int abort_after);
    logic [35:0] first;
    first = '0;
    @(negedge clk);
    start = 1; write_enable = wr; read_enable = rd; mem_address = a; data_in = d;
    if (wr) begin
      model_write(a, d);
      exp_done_q.push_back({1'b0, model_word});
      first = exp_q[exp_q.size() - 6];
    end else if (rd) begin
      model_read(a);
      for (int k = 0; k < 4; k++) rd_bytes_q.push_back(d[k*8 +: 8]);
      model_word = d;
      exp_done_q.push_back({1'b1, d});
      first = exp_q[exp_q.size() - 6];
    end
    @(negedge clk);
    start = 0;
    if (wr || rd) begin
      check("busy_after_start", 36'({busy, awvalid, wvalid}), 36'(3'b111));
      check("first_cmd", {awaddr, wdata}, first);
      mem_address = 11'($urandom); data_in = $urandom;
      write_enable = 1'($urandom); read_enable = 1'($urandom);
      if (pulse_busy) begin
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
      end
      if (abort_after > 0) begin
        repeat (abort_after) @(negedge clk);
        apply_reset();
        repeat (3) @(negedge clk);
        check("no_resume", 36'({busy, awvalid, wvalid, arvalid, bready}), 36'(0));
      end else wait_idle(400);
    end else begin
      check("ignored_start", 36'({busy, awvalid}), 36'(0));
    end
    write_enable = 0; read_enable = 0;
  endtask

  initial begin : main
    start = 0; write_enable = 0; read_enable = 0; mem_address = '0; data_in = '0;
    #1 rst = 0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1;

    do_req(1, 0, 11'h005, 32'hA5A5_A5A5, 0, 0);
    do_req(0, 1, 11'h005, 32'h4433_2211, 0, 0);
    force_inv = 1;
    do_req(0, 1, 11'h123, 32'hDEAD_BEEF, 0, 0);
    do_req(1, 0, 11'h7FC, 32'h0123_4567, 0, 0);
    do_req(1, 1, 11'h3C1, 32'h89AB_CDEF, 0, 0);

    aw_dly_cfg = 3; bp_seen = 0;
    do_req(1, 0, 11'h2A0, 32'hC0FF_EE11, 1, 0);
    check("bp_wvalid_early", 36'(bp_seen > 0), 36'(1));
    aw_dly_cfg = 0;

    do_req(0, 0, 11'h111, 32'h1, 0, 0);
    do_req(0, 1, 11'h010, 32'h55AA_33CC, 0, 0);
    do_req(1, 0, 11'h020, 32'h1357_9BDF, 0, 4);
    do_req(0, 1, 11'h6E4, 32'h0F1E_2D3C, 0, 0);

    for (int i = 0; i < 24; i++) begin
      int op;
      op = int'($urandom_range(0, 5));
      aw_dly_cfg = -1; w_dly_cfg = -1; b_dly_cfg = -1; ar_dly_cfg = -1; r_dly_cfg = -1;
      inv_pct = 20;
      do_req(op < 2 || op == 5, op == 2 || op == 3 || op == 5,
             11'($urandom_range(0, 2047)), $urandom, $urandom_range(0, 3) == 0, 0);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 36'(exp_q.size()), 36'(0));
    check("exp_done_drained", 36'(exp_done_q.size()), 36'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
